cam_frame_capture: RTL
======================

# cam_frame_capture

Parametrised camera capture engine between the OV7670-style camera pins and the frame RAM that the VGA path reads. It samples the camera bus in the system clock domain and pairs RGB565 bytes into pixels. It converts each pixel to grayscale or thresholded luma of configurable width and emits a linear write stream (address, data, strobe) for a dual-port frame buffer. Successor to the fixed 1-bit capture path: it adds resolution and pixel-width parameters, mode selection, arming/single-shot control, frame counting and error flagging.

## Interface

Parameters:
- H_ACTIVE, 640, pixels per line written
- V_ACTIVE, 480, lines per frame written
- OUT_W, 1, write-data width (1..8), MSBs of luma
- ADDR_W, 19, write-address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  active-high, asynchronous reset
- cam_pclk  in  1  camera pixel clock, asynchronous, ≤ Clk/4
- cam_vsync  in  1  camera VSYNC, high = vertical blank
- cam_href  in  1  camera HREF, high = valid bytes
- cam_data  in  8  camera data byte
- enable  in  1  arm capture (level)
- single_shot  in  1  1: stop after one frame; 0: continuous
- mode  in  1  0: grayscale, 1: threshold
- threshold  in  8  luma threshold for mode 1
- wr_en  out  1  write strobe, one Clk per pixel
- wr_addr  out  ADDR_W  linear address row*H_ACTIVE+col
- wr_data  out  OUT_W  pixel value
- frame_done  out  1  one-cycle pulse at end of each captured frame
- frame_err  out  1  geometry error in current/last frame
- busy  out  1  high in WAIT_VS or ACTIVE
- frame_count  out  8  completed frames, wraps 255→0

## Operation

- All cam_* inputs pass through 2-FF synchronisers; PCLK rising edge = synced(t) & ~synced(t-1). A qualifying edge requires synced HREF high.
- FSM: IDLE → (enable) WAIT_VS → (VSYNC high then low) ACTIVE → (VSYNC rising) DONE → WAIT_VS if enable & ~single_shot, else IDLE. DONE lasts one cycle.
- enable dropped in WAIT_VS → IDLE next cycle; dropped in ACTIVE → frame completes, then IDLE.
- Byte phase toggles on each qualifying edge; cleared on HREF falling and on frame start. Phase 0 byte = {R5,G6[5:3]}, phase 1 byte = {G6[2:0],B5}; pixel completes on phase 1.
- Luma: expand R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; Y=(77*R8+150*G8+29*B8)>>8, 16-bit sum, result 0..255.
- wr_data = mode ? {OUT_W{Y ≥ threshold}} : Y[7:8-OUT_W].
- Address: col counter and line_base register, no multiplier. HREF falling ends a line: line_base += H_ACTIVE, col=0, line_cnt++.
- Pixel with col ≥ H_ACTIVE: dropped, frame_err=1. Line with col < H_ACTIVE at HREF fall: frame_err=1, still advances line_base. Lines with line_cnt ≥ V_ACTIVE: dropped, frame_err=1. VSYNC rising with line_cnt ≠ V_ACTIVE: frame_err=1.
- frame_err cleared on entry to ACTIVE; holds through DONE until next frame start.
- frame_done and frame_count++ in DONE only; no pulse for frames aborted by reset.

## Timing

- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, frame_err 0, busy 0, frame_count 0, phase 0, counters 0.
- Camera pin to edge detect: 3 Clk (2 sync + edge register).
- Pixel latency: edge-detect cycle E captures phase-1 byte. Luma sum registered at E+1. wr_en/wr_addr/wr_data registered, valid at E+2 for exactly one cycle.
- Pipeline flushes: a pixel in flight at VSYNC rising is written before frame_done. frame_done is asserted no earlier than the cycle after the last wr_en.
- Reset mid-frame: immediate clear. The next capture requires a fresh VSYNC high→low, so no partial frame is written.
- HREF falling coincident with a phase-1 edge: the pixel is written first, then the line advances.

## Structure

- Package cam_pkg: FSM state enum (IDLE, WAIT_VS, ACTIVE, DONE), luma coefficients 77/150/29, default H_ACTIVE/V_ACTIVE.
- Sub-module cam_luma: registered RGB565→Y plus mode/threshold/OUT_W reduction, one pipeline stage.

## Test plan

- H_ACTIVE=4, V_ACTIVE=2, OUT_W=8, mode 0: frame of 2 lines × 4 pixels {F800,07E0,001F,FFFF} → writes addr 0..7, data 4C,95,1C,FF repeated, one frame_done, frame_err 0, frame_count 1.
- Same frame, mode 1, OUT_W=1, threshold 80 → data 0,1,0,1 per line.
- Line of 5 pixels in a 4-wide config → 5th dropped, second line starts at addr 4, frame_err 1 after frame_done; next good frame clears it.
- single_shot=1, three frames driven → exactly one frame_done, busy low after it, frame_count 1; single_shot=0 → three pulses, count 3.
- Enable asserted mid-frame (VSYNC low) → no writes until the following VSYNC high→low; reset pulsed mid-line → all outputs 0, no frame_done.
- frame_count preloaded via 255 frames → 256th frame_done wraps it to 0.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, constants and luma helper for the camera capture engine
//
// Contents:
//   cam_state_t  : capture FSM states
//   LUMA_*       : BT.601-style fixed-point luma weights (sum to 256)
//   DEF_*        : default frame geometry
//   rgb565_luma  : RGB565 -> 8-bit luma

package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } cam_state_t;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  // Channels are widened to 8 bits by replicating their MSBs so that full
  // scale maps to 255; the weights sum to 256, so the sum fits in 16 bits.
  function automatic logic [7:0] rgb565_luma(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    sum = 16'(LUMA_R * r8 + LUMA_G * g8 + LUMA_B * b8);
    return sum[15:8];
  endfunction

endpackage

// File: rtl/cam_luma.sv
// rtl/cam_luma.sv - one-stage registered RGB565 to luma conversion with output reduction
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : pixel strobe
//   pixel      : RGB565 pixel
//   mode       : 0 grayscale (luma MSBs), 1 threshold (all bits = luma >= threshold)
//   threshold  : luma threshold for mode 1
//   out_valid  : registered strobe, one cycle after in_valid
//   out_data   : registered OUT_W-bit pixel value

module cam_luma
  import cam_pkg::*;
#(
  parameter int unsigned OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      pixel,
  input  logic             mode,
  input  logic [7:0]       threshold,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  logic [7:0]       y;
  logic [OUT_W-1:0] reduced;

  always_comb begin
    y       = rgb565_luma(pixel);
    reduced = mode ? {OUT_W{y >= threshold}} : y[7 -: OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= reduced;
    end
  end

endmodule

// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - camera bus capture to linear frame-buffer write stream
//
// Ports:
//   Clk, Reset                    : system clock, asynchronous active-high reset
//   cam_pclk/vsync/href/data      : raw camera pins (asynchronous to Clk)
//   enable, single_shot           : arm level, stop after one frame
//   mode, threshold               : grayscale / threshold selection
//   wr_en, wr_addr, wr_data       : frame-buffer write port, one strobe per pixel
//   frame_done                    : one-cycle pulse per completed frame
//   frame_err                     : geometry error seen in current/last frame
//   busy                          : waiting for a frame or capturing one
//   frame_count                   : completed frames, modulo 256

module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned OUT_W    = 1,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  input  logic              single_shot,
  input  logic              mode,
  input  logic [7:0]        threshold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        frame_count
);

  // col saturates at H_ACTIVE; line_cnt saturates at V_ACTIVE+1 so an
  // overlong frame never wraps back to a "correct" count.
  localparam int unsigned CW = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW = $clog2(V_ACTIVE + 2);

  cam_state_t state;

  logic [1:0] pclk_sync, vs_sync, href_sync;
  logic [7:0] data_meta, data_s;
  logic       pclk_d, vs_d, href_d;

  logic [7:0]        hi_byte;
  logic              phase;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line_cnt;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr_s1;
  logic              vs_seen;
  logic              end_pending;
  logic              shot_taken;

  logic             luma_valid;
  logic [OUT_W-1:0] luma_data;

  logic          pclk_rise, href_s, vs_s, href_fall, vs_rise;
  logic          capturing, qual, pix_done, in_window, pix_accept;
  logic          frame_start, to_done;
  logic [CW-1:0] col_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      href_sync <= '0;
      data_meta <= '0;
      data_s    <= '0;
      pclk_d    <= 1'b0;
      vs_d      <= 1'b0;
      href_d    <= 1'b0;
    end else begin
      pclk_sync <= {pclk_sync[0], cam_pclk};
      vs_sync   <= {vs_sync[0], cam_vsync};
      href_sync <= {href_sync[0], cam_href};
      data_meta <= cam_data;
      data_s    <= data_meta;
      pclk_d    <= pclk_sync[1];
      vs_d      <= vs_sync[1];
      href_d    <= href_sync[1];
    end
  end

  always_comb begin
    href_s      = href_sync[1];
    vs_s        = vs_sync[1];
    pclk_rise   = pclk_sync[1] & ~pclk_d;
    href_fall   = href_d & ~href_s;
    vs_rise     = vs_s & ~vs_d;
    capturing   = (state == ACTIVE);
    qual        = capturing & pclk_rise & href_s;
    pix_done    = qual & phase;
    in_window   = (col < CW'(H_ACTIVE)) && (line_cnt < LW'(V_ACTIVE));
    pix_accept  = pix_done & in_window;
    col_next    = (pix_done && col < CW'(H_ACTIVE)) ? col + CW'(1) : col;
    frame_start = (state == WAIT_VS) & enable & vs_seen & ~vs_s;
    // Hold off DONE until nothing is left in the two-stage write pipeline,
    // so frame_done always follows the frame's last wr_en.
    to_done     = capturing & (vs_rise | end_pending) & ~pix_accept & ~luma_valid;
  end

  // Byte pairing, geometry counters and error tracking.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_byte   <= '0;
      phase     <= 1'b0;
      col       <= '0;
      line_cnt  <= '0;
      line_base <= '0;
      addr_s1   <= '0;
      frame_err <= 1'b0;
    end else if (frame_start) begin
      phase     <= 1'b0;
      col       <= '0;
      line_cnt  <= '0;
      line_base <= '0;
      frame_err <= 1'b0;
    end else if (capturing) begin
      if (qual) begin
        phase <= ~phase;
        if (!phase) hi_byte <= data_s;
      end
      col <= col_next;
      if (pix_done && !in_window) frame_err <= 1'b1;
      if (pix_accept) addr_s1 <= line_base + ADDR_W'(col);
      // A pixel completing on the same edge as HREF fall has already taken
      // its address above; the line advance below only affects later pixels.
      if (href_fall) begin
        phase     <= 1'b0;
        col       <= '0;
        line_base <= line_base + ADDR_W'(H_ACTIVE);
        if (line_cnt != LW'(V_ACTIVE + 1)) line_cnt <= line_cnt + LW'(1);
        if (col_next < CW'(H_ACTIVE)) frame_err <= 1'b1;
      end
      if (to_done && line_cnt != LW'(V_ACTIVE)) frame_err <= 1'b1;
    end
  end

  cam_luma #(
    .OUT_W(OUT_W)
  ) u_luma (
    .clk      (Clk),
    .rst      (Reset),
    .in_valid (pix_accept),
    .pixel    ({hi_byte, data_s}),
    .mode     (mode),
    .threshold(threshold),
    .out_valid(luma_valid),
    .out_data (luma_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= luma_valid;
      if (luma_valid) begin
        wr_addr <= addr_s1;
        wr_data <= luma_data;
      end
    end
  end

  // shot_taken makes a single-shot capture consume the arm: enable must be
  // dropped before another frame is taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      vs_seen     <= 1'b0;
      end_pending <= 1'b0;
      shot_taken  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) shot_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !shot_taken) begin
            state   <= WAIT_VS;
            busy    <= 1'b1;
            vs_seen <= 1'b0;
          end
        end
        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (frame_start) begin
            state       <= ACTIVE;
            end_pending <= 1'b0;
          end else if (vs_s) begin
            vs_seen <= 1'b1;
          end
        end
        ACTIVE: begin
          if (to_done) begin
            state       <= DONE;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else if (vs_rise) begin
            end_pending <= 1'b1;
          end
        end
        DONE: begin
          if (enable && !single_shot) begin
            state   <= WAIT_VS;
            busy    <= 1'b1;
            vs_seen <= 1'b0;
          end else begin
            state <= IDLE;
            if (single_shot) shot_taken <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
